// File: rtl/decode_ctrl_queue.sv
// decode_ctrl_queue
//   Registered RV32I decode stage between the F/D boundary and the E stage.
//   Each accepted instruction is decoded combinationally and its E-stage
//   control fields are queued, together with a tag (normally the PC), in a
//   DEPTH-entry FIFO. A saturating counter records accepted illegal words.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   upstream handshake (in_ready = count < DEPTH)
//   in_instr, in_tag      instruction word and its payload
//   flush                 synchronous discard of every queued entry
//   out_valid / out_ready E-stage handshake (out_valid = count != 0)
//   out_tag, *E           head payload and control fields (0 when empty)
//   illegal_count         saturating count of accepted illegal instructions
module decode_ctrl_queue #(
    parameter int TAG_WIDTH = 32,
    parameter int DEPTH     = 2,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_instr,
    input  logic [TAG_WIDTH-1:0] in_tag,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [TAG_WIDTH-1:0] out_tag,
    output logic                 RegWriteE,
    output logic                 MemWriteE,
    output logic                 JumpE,
    output logic                 BranchE,
    output logic                 ALUSrcE,
    output logic                 ALUSrcAE,
    output logic                 JALRInstrE,
    output logic                 IllegalE,
    output logic [1:0]           ResultSrcE,
    output logic [3:0]           ALUControlE,
    output logic [2:0]           ImmSrcE,
    output logic [2:0]           AddressingControlE,
    output logic [CNT_WIDTH-1:0] illegal_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CW    = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef struct packed {
        logic       reg_write;
        logic       mem_write;
        logic       jump;
        logic       branch;
        logic       alu_src;
        logic       alu_src_a;
        logic       jalr;
        logic       illegal;
        logic [1:0] result_src;
        logic [3:0] alu_control;
        logic [2:0] imm_src;
        logic [2:0] addr_ctrl;
    } ctrl_t;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    ctrl_t      raw;
    ctrl_t      dec;
    logic       illegal;

    assign opcode = in_instr[6:0];
    assign f3     = in_instr[14:12];
    assign f7     = in_instr[31:25];

    // Register and immediate fields are consumed by later stages, not here.
    logic unused_fields;
    assign unused_fields = ^{in_instr[24:15], in_instr[11:7]};

    // NOTE: every variable driven in always_comb gets a default first, so no path can leave it holding its old value (that would infer a latch).
    always_comb begin
        raw     = '0;
        illegal = 1'b0;
        case (opcode)
            7'b0110011: begin // R-type
                raw.reg_write = 1'b1;
                case (f3)
                    3'b000:  raw.alu_control = f7[5] ? 4'b0001 : 4'b0000;
                    3'b001:  raw.alu_control = 4'b0111;
                    3'b010:  raw.alu_control = 4'b0101;
                    3'b011:  raw.alu_control = 4'b0110;
                    3'b100:  raw.alu_control = 4'b0100;
                    3'b101:  raw.alu_control = f7[5] ? 4'b1011 : 4'b1000;
                    3'b110:  raw.alu_control = 4'b0011;
                    default: raw.alu_control = 4'b0010;
                endcase
                illegal = !((f7 == 7'b0000000) ||
                            (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)));
            end
            7'b0010011: begin // I-type ALU
                raw.reg_write = 1'b1;
                raw.alu_src   = 1'b1;
                case (f3)
                    3'b000: raw.alu_control = 4'b0000;
                    3'b001: begin
                        raw.alu_control = 4'b0111;
                        illegal         = (f7 != 7'b0000000);
                    end
                    3'b010: raw.alu_control = 4'b0101;
                    3'b011: raw.alu_control = 4'b0110;
                    3'b100: raw.alu_control = 4'b0100;
                    3'b101: begin
                        if (f7 == 7'b0000000)      raw.alu_control = 4'b1000;
                        else if (f7 == 7'b0100000) raw.alu_control = 4'b1011;
                        else                       illegal = 1'b1;
                    end
                    3'b110:  raw.alu_control = 4'b0011;
                    default: raw.alu_control = 4'b0010;
                endcase
            end
            7'b0000011: begin // load: widths 011, 110, 111 do not exist
                raw.reg_write  = 1'b1;
                raw.result_src = 2'b01;
                raw.alu_src    = 1'b1;
                raw.addr_ctrl  = f3;
                illegal        = (f3 == 3'b011) || (f3[2:1] == 2'b11);
            end
            7'b0100011: begin // store: only byte, half, word
                raw.mem_write = 1'b1;
                raw.alu_src   = 1'b1;
                raw.imm_src   = 3'b001;
                raw.addr_ctrl = f3;
                illegal       = (f3 >= 3'b011);
            end
            7'b1100011: begin // branch
                raw.branch  = 1'b1;
                raw.imm_src = 3'b010;
                case (f3)
                    3'b000:  raw.alu_control = 4'b0001;
                    3'b001:  raw.alu_control = 4'b1100;
                    3'b100:  raw.alu_control = 4'b0101;
                    3'b101:  raw.alu_control = 4'b1001;
                    3'b110:  raw.alu_control = 4'b0110;
                    3'b111:  raw.alu_control = 4'b1010;
                    default: illegal = 1'b1;
                endcase
            end
            7'b1101111: begin // JAL
                raw.reg_write  = 1'b1;
                raw.result_src = 2'b10;
                raw.imm_src    = 3'b011;
                raw.jump       = 1'b1;
            end
            7'b1100111: begin // JALR
                raw.reg_write  = 1'b1;
                raw.result_src = 2'b10;
                raw.jump       = 1'b1;
                raw.alu_src    = 1'b1;
                raw.jalr       = 1'b1;
                illegal        = (f3 != 3'b000);
            end
            7'b0110111: begin // LUI
                raw.reg_write   = 1'b1;
                raw.alu_control = 4'b1111;
                raw.alu_src     = 1'b1;
                raw.imm_src     = 3'b100;
            end
            7'b0010111: begin // AUIPC: ALU adds PC (source A) and U-immediate
                raw.reg_write = 1'b1;
                raw.alu_src   = 1'b1;
                raw.alu_src_a = 1'b1;
                raw.imm_src   = 3'b100;
            end
            default: illegal = 1'b1;
        endcase
    end

    // An illegal word carries no control at all, only the flag.
    always_comb begin
        dec = raw;
        if (illegal) begin
            dec         = '0;
            dec.illegal = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic [CW-1:0]    count;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    ctrl_t            ctrl_mem [DEPTH];
    logic [TAG_WIDTH-1:0] tag_mem [DEPTH];
    logic             push;
    logic             pop;

    assign in_ready  = (count < FULL);
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready & ~flush;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count         <= '0;
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            illegal_count <= '0;
        end else begin
            if (flush) begin
                count  <= '0;
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                // Pointers are power-of-two wide, so the adds wrap modulo DEPTH.
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                if (push && !pop)      count <= count + 1'b1;
                else if (pop && !push) count <= count - 1'b1;
            end
            if (push && dec.illegal && illegal_count != '1)
                illegal_count <= illegal_count + 1'b1;
        end
    end

    // NOTE: the storage array is deliberately not reset; the head is masked by out_valid, so stale contents are never observable.
    always_ff @(posedge clk) begin
        if (push) begin
            ctrl_mem[wr_ptr] <= dec;
            tag_mem[wr_ptr]  <= in_tag;
        end
    end

    // Head outputs read 0 whenever the queue is empty (including in reset).
    ctrl_t head;
    assign head    = out_valid ? ctrl_mem[rd_ptr] : '0;
    assign out_tag = out_valid ? tag_mem[rd_ptr]  : '0;

    assign RegWriteE          = head.reg_write;
    assign MemWriteE          = head.mem_write;
    assign JumpE              = head.jump;
    assign BranchE            = head.branch;
    assign ALUSrcE            = head.alu_src;
    assign ALUSrcAE           = head.alu_src_a;
    assign JALRInstrE         = head.jalr;
    assign IllegalE           = head.illegal;
    assign ResultSrcE         = head.result_src;
    assign ALUControlE        = head.alu_control;
    assign ImmSrcE            = head.imm_src;
    assign AddressingControlE = head.addr_ctrl;

endmodule

// File: tb/tb_decode_ctrl_queue.sv
// Directed bench for decode_ctrl_queue (DEPTH=2, CNT_WIDTH=2).
module tb_decode_ctrl_queue;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_tag;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_tag;
    logic        RegWriteE, MemWriteE, JumpE, BranchE;
    logic        ALUSrcE, ALUSrcAE, JALRInstrE, IllegalE;
    logic [1:0]  ResultSrcE;
    logic [3:0]  ALUControlE;
    logic [2:0]  ImmSrcE;
    logic [2:0]  AddressingControlE;
    logic [1:0]  illegal_count;

    int checks = 0;
    int errors = 0;

    decode_ctrl_queue #(.TAG_WIDTH(32), .DEPTH(2), .CNT_WIDTH(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_tag(in_tag), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .JumpE(JumpE),
        .BranchE(BranchE), .ALUSrcE(ALUSrcE), .ALUSrcAE(ALUSrcAE),
        .JALRInstrE(JALRInstrE), .IllegalE(IllegalE),
        .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE),
        .ImmSrcE(ImmSrcE), .AddressingControlE(AddressingControlE),
        .illegal_count(illegal_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // All E outputs gathered into one word for compact comparison.
    logic [19:0] e_bus;
    assign e_bus = {RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ALUSrcAE,
                    JALRInstrE, IllegalE, ResultSrcE, ALUControlE, ImmSrcE,
                    AddressingControlE};

    function automatic logic [19:0] ctl(input bit rw, mw, j, b, as, asa, jr, il,
                                        input logic [1:0] rs, input logic [3:0] alu,
                                        input logic [2:0] imm, input logic [2:0] ad);
        return {rw, mw, j, b, as, asa, jr, il, rs, alu, imm, ad};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Push one instruction with out_ready=1; it becomes the head after the edge.
    task automatic push_check(input string name, input logic [31:0] instr,
                              input logic [31:0] tag, input logic [19:0] exp,
                              input logic [1:0] exp_cnt);
        in_valid = 1'b1;
        in_instr = instr;
        in_tag   = tag;
        tick();
        check({name, " valid"}, {31'b0, out_valid}, 32'd1);
        check({name, " ctrl"}, {12'b0, e_bus}, {12'b0, exp});
        check({name, " tag"}, out_tag, tag);
        check({name, " icnt"}, {30'b0, illegal_count}, {30'b0, exp_cnt});
    endtask

    localparam logic [19:0] C_ADDI  = ctl(1,0,0,0,1,0,0,0, 2'b00, 4'b0000, 3'b000, 3'b000);
    localparam logic [19:0] C_ADD   = ctl(1,0,0,0,0,0,0,0, 2'b00, 4'b0000, 3'b000, 3'b000);
    localparam logic [19:0] C_SUB   = ctl(1,0,0,0,0,0,0,0, 2'b00, 4'b0001, 3'b000, 3'b000);
    localparam logic [19:0] C_AUIPC = ctl(1,0,0,0,1,1,0,0, 2'b00, 4'b0000, 3'b100, 3'b000);
    localparam logic [19:0] C_ILL   = ctl(0,0,0,0,0,0,0,1, 2'b00, 4'b0000, 3'b000, 3'b000);
    localparam logic [19:0] C_LW    = ctl(1,0,0,0,1,0,0,0, 2'b01, 4'b0000, 3'b000, 3'b010);
    localparam logic [19:0] C_SW    = ctl(0,1,0,0,1,0,0,0, 2'b00, 4'b0000, 3'b001, 3'b010);
    localparam logic [19:0] C_BNE   = ctl(0,0,0,1,0,0,0,0, 2'b00, 4'b1100, 3'b010, 3'b000);
    localparam logic [19:0] C_JAL   = ctl(1,0,1,0,0,0,0,0, 2'b10, 4'b0000, 3'b011, 3'b000);
    localparam logic [19:0] C_JALR  = ctl(1,0,1,0,1,0,1,0, 2'b10, 4'b0000, 3'b000, 3'b000);
    localparam logic [19:0] C_LUI   = ctl(1,0,0,0,1,0,0,0, 2'b00, 4'b1111, 3'b100, 3'b000);
    localparam logic [19:0] C_SRAI  = ctl(1,0,0,0,1,0,0,0, 2'b00, 4'b1011, 3'b000, 3'b000);
    localparam logic [19:0] C_SLTU  = ctl(1,0,0,0,0,0,0,0, 2'b00, 4'b0110, 3'b000, 3'b000);

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = 32'h0;
        in_tag    = 32'h0;
        flush     = 1'b0;
        out_ready = 1'b0;

        // ---- reset state ----
        #12;
        check("rst out_valid", {31'b0, out_valid}, 32'd0);
        check("rst in_ready", {31'b0, in_ready}, 32'd1);
        check("rst ctrl", {12'b0, e_bus}, 32'd0);
        check("rst tag", out_tag, 32'd0);
        check("rst icnt", {30'b0, illegal_count}, 32'd0);
        rst_n = 1'b1;

        // ---- single addi, one-cycle latency, then drains ----
        out_ready = 1'b1;
        push_check("addi", 32'h00500093, 32'h100, C_ADDI, 2'd0);
        in_valid = 1'b0;
        tick();
        check("drain valid", {31'b0, out_valid}, 32'd0);
        check("drain ctrl", {12'b0, e_bus}, 32'd0);
        check("drain tag", out_tag, 32'd0);
        check("drain in_ready", {31'b0, in_ready}, 32'd1);

        // ---- backpressure: fill to DEPTH, third held upstream ----
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h00100113; in_tag = 32'h200;   // addi
        tick();
        check("bp1 in_ready", {31'b0, in_ready}, 32'd1);
        in_instr  = 32'h002081B3; in_tag = 32'h204;   // add
        tick();
        check("bp2 in_ready", {31'b0, in_ready}, 32'd0);
        check("bp2 head tag", out_tag, 32'h200);
        in_instr  = 32'h40208233; in_tag = 32'h208;   // sub, must be held
        tick();
        check("bp3 in_ready", {31'b0, in_ready}, 32'd0);
        check("bp3 head tag", out_tag, 32'h200);
        check("bp3 head ctrl", {12'b0, e_bus}, {12'b0, C_ADDI});
        out_ready = 1'b1;
        tick();                                          // pop addi only
        check("bp4 head tag", out_tag, 32'h204);
        check("bp4 head ctrl", {12'b0, e_bus}, {12'b0, C_ADD});
        check("bp4 in_ready", {31'b0, in_ready}, 32'd1);
        tick();                                          // pop add, push sub
        check("bp5 head tag", out_tag, 32'h208);
        check("bp5 head ctrl", {12'b0, e_bus}, {12'b0, C_SUB});
        check("bp5 valid", {31'b0, out_valid}, 32'd1);
        in_valid = 1'b0;
        tick();
        check("bp6 valid", {31'b0, out_valid}, 32'd0);
        check("bp6 in_ready", {31'b0, in_ready}, 32'd1);

        // ---- sub / auipc / all-ones ----
        push_check("sub", 32'h40000033, 32'h300, C_SUB, 2'd0);
        push_check("auipc", 32'h00000017, 32'h304, C_AUIPC, 2'd0);
        push_check("ones", 32'hFFFFFFFF, 32'h308, C_ILL, 2'd1);
        in_valid = 1'b0;
        tick();
        check("seq empty", {31'b0, out_valid}, 32'd0);

        // ---- fill then flush with an illegal word presented ----
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h00012083; in_tag = 32'h400;   // lw
        tick();
        check("fill lw ctrl", {12'b0, e_bus}, {12'b0, C_LW});
        in_instr  = 32'h00112023; in_tag = 32'h404;   // sw
        tick();
        check("fill full", {31'b0, in_ready}, 32'd0);
        flush    = 1'b1;
        in_instr = 32'hFFFFFFFF; in_tag = 32'h408;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush valid", {31'b0, out_valid}, 32'd0);
        check("flush in_ready", {31'b0, in_ready}, 32'd1);
        check("flush ctrl", {12'b0, e_bus}, 32'd0);
        check("flush icnt", {30'b0, illegal_count}, 32'd1);

        // ---- remaining opcode classes ----
        out_ready = 1'b1;
        push_check("sw", 32'h00112023, 32'h500, C_SW, 2'd1);
        push_check("bne", 32'h00001063, 32'h504, C_BNE, 2'd1);
        push_check("jal", 32'h0000006F, 32'h508, C_JAL, 2'd1);
        push_check("jalr", 32'h00008067, 32'h50C, C_JALR, 2'd1);
        push_check("lui", 32'h000010B7, 32'h510, C_LUI, 2'd1);
        push_check("srai", 32'h4010D093, 32'h514, C_SRAI, 2'd1);
        push_check("sltu", 32'h0020B1B3, 32'h518, C_SLTU, 2'd1);

        // ---- illegal field combinations, counter saturates at 3 ----
        push_check("r f7 bad", 32'h40001033, 32'h600, C_ILL, 2'd2);
        push_check("ld f3 bad", 32'h00003003, 32'h604, C_ILL, 2'd3);
        push_check("jalr f3 bad", 32'h00001067, 32'h608, C_ILL, 2'd3);
        push_check("br f3 bad", 32'h00002063, 32'h60C, C_ILL, 2'd3);
        push_check("slli f7 bad", 32'h40001013, 32'h610, C_ILL, 2'd3);
        in_valid = 1'b0;
        tick();
        check("ill empty", {31'b0, out_valid}, 32'd0);

        // ---- asynchronous reset with one entry queued ----
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h00500093; in_tag = 32'h700;
        tick();
        in_valid = 1'b0;
        check("pre-rst valid", {31'b0, out_valid}, 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst valid", {31'b0, out_valid}, 32'd0);
        check("arst ctrl", {12'b0, e_bus}, 32'd0);
        check("arst tag", out_tag, 32'd0);
        check("arst icnt", {30'b0, illegal_count}, 32'd0);
        check("arst in_ready", {31'b0, in_ready}, 32'd1);
        #2;
        rst_n = 1'b1;
        tick();
        check("post-rst valid", {31'b0, out_valid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/decode_ctrl_queue.md
Name: decode_ctrl_queue

Overview:
- Registered successor to the combinational decode control unit, sitting between the F/D boundary and the E stage.
- Decodes each accepted 32-bit RV32I instruction into E-stage control fields, and adds AUIPC plus illegal-instruction detection.
- Buffers decoded entries and their tag (PC or other payload) in a DEPTH-entry FIFO with valid/ready handshakes on both sides.
- Supports a pipeline flush and keeps a saturating illegal-instruction counter.

Parameters:
- TAG_WIDTH, 32, width of the payload carried alongside each instruction (normally the PC).
- DEPTH, 2, number of FIFO entries; must be a power of two and at least 2.
- CNT_WIDTH, 8, width of the illegal-instruction counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream has an instruction.
- in_ready  out  1  block can accept; equals (count < DEPTH).
- in_instr  in  32  instruction word.
- in_tag  in  TAG_WIDTH  payload.
- flush  in  1  synchronous discard of all entries.
- out_valid  out  1  head entry valid; equals (count != 0).
- out_ready  in  1  E stage consumes head.
- out_tag  out  TAG_WIDTH  head payload.
- RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ALUSrcAE, JALRInstrE, IllegalE  out  1 each  head control bits.
- ResultSrcE  out  2  head control field.
- ALUControlE  out  4  head control field.
- ImmSrcE  out  3  head control field.
- AddressingControlE  out  3  head control field.
- illegal_count  out  CNT_WIDTH  saturating count of accepted illegal instructions.

Behaviour:
- Reset (rst_n low, asynchronous):
  - count, read pointer, write pointer and illegal_count go to 0.
  - out_valid = 0; in_ready = 1.
  - All E outputs and out_tag are 0.
- Push and pop:
  - push = in_valid & in_ready & !flush.
  - pop = out_valid & out_ready & !flush.
  - Decode happens combinationally at push; the decoded fields and tag are written at the clock edge.
  - Latency: an instruction pushed at edge N is visible at the head after edge N, i.e. out_valid is high in cycle N+1 if the FIFO was empty.
- Count and pointer rules:
  - Push and pop in the same cycle: count unchanged; both pointers advance.
  - Full (count = DEPTH): in_ready = 0, so no push is possible.
  - Empty: out_valid = 0 and every E output and out_tag reads 0 (the head is masked, not stale).
  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- Flush:
  - Takes priority over push and pop. Next cycle: count = 0, pointers equal, out_valid = 0.
  - Any in_valid presented in the flush cycle is dropped and not counted.
  - illegal_count is not cleared by flush.
- illegal_count: increments by 1 on each push whose decode is illegal; holds at 2^CNT_WIDTH-1.
- Decode defaults: every field is 0 unless listed for that opcode. f3 = instr[14:12]; f7 = instr[31:25].
- R-type 0110011: RegWrite=1. ALUControl by f3:
  - 000: add 0000 (f7=0000000) or sub 0001 (f7=0100000).
  - 001 sll 0111; 010 slt 0101; 011 sltu 0110; 100 xor 0100; 110 or 0011; 111 and 0010.
  - 101: srl 1000 (f7=0000000) or sra 1011 (f7=0100000).
  - Legal only with f7=0000000, or f7=0100000 with f3 of 000 or 101.
- I-ALU 0010011: RegWrite=1, ALUSrc=1, ImmSrc=000.
  - 000 addi 0000; 010 slti 0101; 011 sltiu 0110; 100 xori 0100; 110 ori 0011; 111 andi 0010.
  - 001 slli 0111, legal only if f7=0000000.
  - 101: srli 1000 (f7=0000000) or srai 1011 (f7=0100000); any other f7 is illegal.
- Load 0000011: RegWrite=1, ResultSrc=01, ALUSrc=1, AddressingControl=f3. f3 of 011, 110 or 111 is illegal.
- Store 0100011: MemWrite=1, ALUSrc=1, ImmSrc=001, AddressingControl=f3. f3 ≥ 011 is illegal.
- Branch 1100011: Branch=1, ImmSrc=010. ALUControl:
  - beq 0001; bne 1100; blt 0101; bge 1001; bltu 0110; bgeu 1010.
  - f3 of 010 or 011 is illegal.
- JAL 1101111: RegWrite=1, ResultSrc=10, ImmSrc=011, Jump=1.
- JALR 1100111: RegWrite=1, ResultSrc=10, Jump=1, ALUSrc=1, JALRInstr=1. f3 ≠ 000 is illegal.
- LUI 0110111: RegWrite=1, ALUControl=1111, ALUSrc=1, ImmSrc=100.
- AUIPC 0010111: RegWrite=1, ALUControl=0000, ALUSrc=1, ALUSrcA=1, ImmSrc=100.
- Any other opcode is illegal.
- Illegal instructions: every control field is forced to 0 and IllegalE=1. The entry is still queued and its tag is carried.

Test Plan:
- Reset, then push 0x00500093 (addi x1,x0,5) with tag 0x100, out_ready=1 → next cycle out_valid=1, RegWriteE=1, ALUSrcE=1, ALUControlE=0000, out_tag=0x100; the following cycle out_valid=0 with all outputs 0.
- out_ready=0 and push 3 instructions back-to-back (DEPTH=2) → in_ready drops to 0 after the 2nd push; the 3rd is held upstream. Raise out_ready → entries emerge in order, pointers wrap, and in_ready returns to 1.
- Push 0x40000033 (sub), 0x00000017 (auipc), 0xFFFFFFFF → ALUControlE = 0001, then ALUSrcAE=1 with ImmSrcE=100, then IllegalE=1 with all other fields 0; illegal_count = 1.
- Fill the FIFO, assert flush with in_valid=1 carrying an illegal instruction → next cycle out_valid=0, in_ready=1, illegal_count unchanged.
- CNT_WIDTH=2, push 5 illegal instructions → illegal_count saturates at 3.
- Assert rst_n low mid-stream with 1 entry queued → out_valid and all outputs read 0 immediately (no clock edge needed); illegal_count=0.
